// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: control-bit positions and FSM states.
package mem_stage_pkg;

  // Bit positions inside Mem_ctrl
  localparam int MC_BRANCH = 2;
  localparam int MC_READ   = 1;
  localparam int MC_WRITE  = 0;

  // Bit positions inside WB_ctrl
  localparam int WB_REGW = 1;
  localparam int WB_M2R  = 0;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/mem_stage_data_mem.sv
// Word-addressed data memory: synchronous write, asynchronous read.
module data_mem #(
  parameter int    DEPTH     = 256,
  parameter string INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: the array has no reset branch on purpose; clearing it on reset would
  // force every word into flops instead of a RAM macro.
  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge value of its inputs.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: branch resolution, fixed-latency
// data-memory access with upstream stall, address checking and the MEM/WB latch.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int    DEPTH     = 256,
  parameter int    MEM_LAT   = 2,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  WB_ctrl,
  input  logic [2:0]  Mem_ctrl,
  input  logic [31:0] EX_adder,
  input  logic [31:0] EX_ALU,
  input  logic        EX_zero,
  input  logic [31:0] EXMux0_latch,
  input  logic [4:0]  EXMux1,
  output logic        PCSrc,
  output logic [31:0] branch_target,
  output logic        mem_stall,
  output logic        mem_err,
  output logic [1:0]  MEM_WB_ctrl,
  output logic [31:0] MEM_WB_rdata,
  output logic [31:0] MEM_WB_alu,
  output logic [4:0]  MEM_WB_dst
);

  localparam int AW = $clog2(DEPTH);
  // The counter holds the stall cycles still owed after the presentation cycle.
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  logic          mem_rd, mem_wr, mem_op;
  logic          addr_bad, conflict, load_ok;
  logic          stall_c, commit, mem_we;
  logic [31:0]   mem_rdata;
  state_t        state;
  logic [CW-1:0] cnt;

  assign mem_rd   = Mem_ctrl[MC_READ];
  assign mem_wr   = Mem_ctrl[MC_WRITE];
  assign mem_op   = mem_rd | mem_wr;
  assign addr_bad = mem_op & ((EX_ALU[1:0] != 2'b00) | ((EX_ALU >> (AW + 2)) != 32'd0));
  assign conflict = mem_rd & mem_wr;
  assign load_ok  = mem_rd & ~mem_wr & ~addr_bad;

  assign PCSrc         = Mem_ctrl[MC_BRANCH] & EX_zero;
  assign branch_target = EX_adder;

  // commit marks the edge at which the store lands and MEM/WB is loaded.
  always_comb begin
    // NOTE: defaults first so no path through this block leaves a signal
    // unassigned, which would infer a latch.
    stall_c = 1'b0;
    commit  = 1'b0;
    if (state == S_IDLE) stall_c = mem_op && (MEM_LAT != 0);
    else                 stall_c = (cnt != '0);
    commit = ~stall_c;
  end

  // Reset gates both so an aborted access neither stalls nor writes.
  assign mem_stall = rst_n & stall_c;
  assign mem_we    = rst_n & commit & mem_wr & ~addr_bad;

  data_mem #(
    .DEPTH    (DEPTH),
    .INIT_FILE(INIT_FILE)
  ) u_data_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (EX_ALU[AW+1:2]),
    .wdata(EXMux0_latch),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      mem_err      <= 1'b0;
      MEM_WB_ctrl  <= '0;
      MEM_WB_rdata <= '0;
      MEM_WB_alu   <= '0;
      MEM_WB_dst   <= '0;
    end else begin
      mem_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mem_op && (MEM_LAT != 0)) begin
            state       <= S_BUSY;
            cnt         <= CW'(MEM_LAT - 1);
            MEM_WB_ctrl <= '0;   // bubble; data fields keep their last value
          end
        end
        S_BUSY: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          else           state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (commit) begin
        MEM_WB_ctrl  <= WB_ctrl;
        MEM_WB_alu   <= EX_ALU;
        MEM_WB_dst   <= EXMux1;
        MEM_WB_rdata <= load_ok ? mem_rdata : 32'd0;
        mem_err      <= addr_bad | conflict;
      end
    end
  end

endmodule
